// File: rtl/sd_sector_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_sector_port: per-drive sector client for sd_card with a private buffer.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sd_sector_port #(
  parameter int          DRIVE   = 0,
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mounted,
  input  logic [63:0] image_size,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_sector,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_wdata,
  input  logic        buf_we,
  output logic [7:0]  buf_rdata,
  output logic [7:0]  rstart,
  output logic [7:0]  wstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic [7:0]  inbyte
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [31:0] c_sec_sat = 32'hFFFF_FFFF;

  logic [2:0]  r_state, w_state_nxt;
  logic [31:0] r_sec_cnt, w_sec_cnt_new;
  logic        r_img_valid;
  logic [31:0] r_rsector, w_rsector_nxt;
  logic        r_dir, w_dir_nxt;
  logic        r_err_r, w_err_r_nxt;
  logic [23:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        r_start, w_start_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_busy, w_busy_nxt;
  logic        w_range_bad, w_timeout, w_sd_we, w_core_we;
  logic [7:0]  r_mem [512];
  logic [7:0]  r_buf_rdata, r_inbyte;
  logic        w_unused_rbusy;

  assign w_unused_rbusy = rbusy;

  // Images of 2^41 bytes or more have more sectors than 32 bits can count.
  assign w_sec_cnt_new = (|image_size[63:41]) ? c_sec_sat : image_size[40:9];
  assign w_range_bad   = !r_img_valid || (r_rsector >= r_sec_cnt);
  assign w_cnt_inc     = r_cnt + 24'd1;
  assign w_timeout     = (TIMEOUT != 24'd0) && (w_cnt_inc == TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sec_cnt   <= 32'd0;
      r_img_valid <= 1'b0;
    end else if (mounted) begin
      r_sec_cnt   <= w_sec_cnt_new;
      r_img_valid <= (w_sec_cnt_new != 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_rd || req_wr) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = w_range_bad ? S_FINISH : S_START;
      S_START:  w_state_nxt = S_WAIT;
      S_WAIT:   if (rdone || w_timeout) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rsector_nxt = r_rsector;
    w_dir_nxt     = r_dir;
    w_err_r_nxt   = r_err_r;
    w_cnt_nxt     = r_cnt;
    w_start_nxt   = r_start;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          w_rsector_nxt = req_sector;
          w_dir_nxt     = req_wr && !req_rd;
        end
      end
      S_CHECK: if (w_range_bad) w_err_r_nxt = 1'b1;
      S_START: begin
        w_start_nxt = 1'b1;
        w_cnt_nxt   = 24'd0;
      end
      S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        // A completion landing on the timeout cycle still counts as success.
        if (rdone) begin
          w_start_nxt = 1'b0;
          w_err_r_nxt = 1'b0;
        end else if (w_timeout) begin
          w_start_nxt = 1'b0;
          w_err_r_nxt = 1'b1;
        end
      end
      S_FINISH: begin
        w_done_nxt = 1'b1;
        w_err_nxt  = r_err_r;
      end
      default: ;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE) || w_done_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsector <= 32'd0;
      r_dir     <= 1'b0;
      r_err_r   <= 1'b0;
      r_cnt     <= 24'd0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rsector <= w_rsector_nxt;
      r_dir     <= w_dir_nxt;
      r_err_r   <= w_err_r_nxt;
      r_cnt     <= w_cnt_nxt;
      r_start   <= w_start_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Core writes are locked out while busy, so the ports never collide.
  assign w_sd_we   = rstn && (r_state == S_WAIT) && !r_dir && outen;
  assign w_core_we = rstn && buf_we && !r_busy;

  always_ff @(posedge clk) begin
    if (w_sd_we)        r_mem[outaddr]  <= outbyte;
    else if (w_core_we) r_mem[buf_addr] <= buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_buf_rdata <= 8'd0;
      r_inbyte    <= 8'd0;
    end else begin
      r_buf_rdata <= r_mem[buf_addr];
      r_inbyte    <= r_mem[outaddr];
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_start_bits
      if (gi == DRIVE) begin : g_drive
        assign rstart[gi] = r_start && !r_dir;
        assign wstart[gi] = r_start && r_dir;
      end else begin : g_other
        assign rstart[gi] = 1'b0;
        assign wstart[gi] = 1'b0;
      end
    end
  endgenerate

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rsector   = r_rsector;
  assign buf_rdata = r_buf_rdata;
  assign inbyte    = r_inbyte;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sd_sector_port: self-checking bench with a transaction-level model.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sd_sector_port;

  localparam int          DRV   = 2;
  localparam int          TO    = 700;
  localparam logic [7:0]  C_BIT = 8'h04;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mounted = 1'b0;
  logic [63:0] image_size = 64'd0;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [31:0] req_sector = 32'd0;
  logic        busy, done, err;
  logic [8:0]  buf_addr = 9'd0;
  logic [7:0]  buf_wdata = 8'd0;
  logic        buf_we = 1'b0;
  logic [7:0]  buf_rdata, rstart, wstart, inbyte;
  logic [31:0] rsector;
  logic        rbusy = 1'b0, rdone = 1'b0, outen = 1'b0;
  logic [8:0]  outaddr = 9'd0;
  logic [7:0]  outbyte = 8'd0;

  sd_sector_port #(.DRIVE(DRV), .TIMEOUT(24'(TO))) dut (
    .clk(clk), .rstn(rstn), .mounted(mounted), .image_size(image_size),
    .req_rd(req_rd), .req_wr(req_wr), .req_sector(req_sector),
    .busy(busy), .done(done), .err(err),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata),
    .rstart(rstart), .wstart(wstart), .rsector(rsector),
    .rbusy(rbusy), .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .inbyte(inbyte)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one record per accepted request, expressed as cycle numbers.
  bit          seen_rst = 1'b0;
  bit          m_act = 1'b0, m_pass, m_dir, m_err;
  longint      m_t0, m_end, m_d;
  logic [31:0] m_rsector = 32'd0, m_sec = 32'd0;
  bit          m_valid = 1'b0;
  logic [7:0]  m_buf [512];
  bit          m_known [512];
  logic [7:0]  m_rd, m_ib;
  bit          m_rd_known = 1'b0, m_ib_known = 1'b0;

  initial for (int i = 0; i < 512; i++) m_known[i] = 1'b0;

  always @(negedge clk) begin
    bit e_busy, e_done, e_err, e_st;
    logic [63:0] q;
    e_busy = m_act && (cyc > m_t0);
    e_done = m_act && (cyc == m_d);
    e_err  = e_done && m_err;
    e_st   = m_act && m_pass && (cyc >= m_t0 + 3) && (m_end < 0 || cyc <= m_end);
    if (seen_rst) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("rstart", rstart, (e_st && !m_dir) ? C_BIT : 8'h00);
      chk("wstart", wstart, (e_st && m_dir) ? C_BIT : 8'h00);
      chk("rsector", rsector, m_rsector);
      if (m_rd_known) chk("buf_rdata", buf_rdata, m_rd);
      if (m_ib_known) chk("inbyte", inbyte, m_ib);
    end
    if (!rstn) begin
      seen_rst = 1'b1;
      m_act = 1'b0; m_rsector = 32'd0; m_sec = 32'd0; m_valid = 1'b0;
      m_rd = 8'd0; m_ib = 8'd0; m_rd_known = 1'b1; m_ib_known = 1'b1;
    end else begin
      m_rd = m_buf[buf_addr]; m_rd_known = m_known[buf_addr];
      m_ib = m_buf[outaddr];  m_ib_known = m_known[outaddr];
      if (e_st && !m_dir && outen) begin
        m_buf[outaddr] = outbyte; m_known[outaddr] = 1'b1;
      end else if (buf_we && !e_busy) begin
        m_buf[buf_addr] = buf_wdata; m_known[buf_addr] = 1'b1;
      end
      if (mounted) begin
        q = image_size / 64'd512;
        m_sec = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
        m_valid = (m_sec != 32'd0);
      end
      if (e_st && m_end < 0) begin
        if (rdone) begin
          m_end = cyc; m_err = 1'b0; m_d = cyc + 2;
        end else if (cyc == m_t0 + 3 + TO - 1) begin
          m_end = cyc; m_err = 1'b1; m_d = cyc + 2;
        end
      end
      if (m_act && cyc == m_d) m_act = 1'b0;
      if (!m_act && (req_rd || req_wr)) begin
        m_act = 1'b1; m_t0 = cyc; m_end = -1;
        m_dir = req_wr && !req_rd;
        m_rsector = req_sector;
        m_pass = m_valid && (req_sector < m_sec);
        m_err = !m_pass;
        m_d = m_pass ? -1 : cyc + 3;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_req(input bit rd, input bit wr, input logic [31:0] sec);
    req_rd = rd; req_wr = wr; req_sector = sec;
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic do_mount(input logic [63:0] sz);
    image_size = sz; mounted = 1'b1;
    tick();
    mounted = 1'b0;
  endtask

  task automatic fill_buf(input bit pattern_is_index, input logic [7:0] val);
    for (int i = 0; i < 512; i++) begin
      buf_we = 1'b1; buf_addr = 9'(i); buf_wdata = pattern_is_index ? 8'(i) : val;
      tick();
    end
    buf_we = 1'b0;
  endtask

  task automatic finish_xfer(input bit exp_err);
    rdone = 1'b1;
    tick();
    rdone = 1'b0;
    chk("start_drop", {rstart, wstart}, 16'h0000);
    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_err", err, exp_err);
    tick();
  endtask

  task automatic run_read(input logic [31:0] sec, input int nbytes, input bit both);
    pulse_req(1'b1, both, sec);
    tick();
    chk("start_not_yet", rstart, 8'h00);
    tick();
    chk("rstart_rise", rstart, C_BIT);
    chk("wstart_idle", wstart, 8'h00);
    for (int i = 0; i < nbytes; i++) begin
      outen = 1'b1; outaddr = 9'(i); outbyte = 8'(i) ^ 8'h5A;
      tick();
    end
    outen = 1'b0;
    finish_xfer(1'b0);
  endtask

  task automatic run_bad(input logic [31:0] sec);
    pulse_req(1'b1, 1'b0, sec);
    chk("bad_busy", busy, 1'b1);
    tick();
    chk("bad_done_early", done, 1'b0);
    tick();
    chk("bad_done", done, 1'b1);
    chk("bad_err", err, 1'b1);
    chk("bad_rstart", rstart, 8'h00);
    tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rstn = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", {rstart, wstart}, 16'h0000);
    chk("rst_rsector", rsector, 32'd0);
    fill_buf(1'b1, 8'h00);
    run_bad(32'd0);                          // no image mounted
    do_mount(64'd174848);                    // 341 whole sectors
    run_read(32'd5, 512, 1'b0);
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i);
      tick();
      chk("readback", buf_rdata, 8'(i) ^ 8'h5A);
    end
    fill_buf(1'b0, 8'hC3);
    pulse_req(1'b0, 1'b1, 32'd340);
    tick(); tick();
    chk("wstart_rise", wstart, C_BIT);
    chk("rstart_idle", rstart, 8'h00);
    for (int i = 0; i < 512; i++) begin
      outaddr = 9'(i);
      tick();
      chk("inbyte", inbyte, 8'hC3);
    end
    finish_xfer(1'b0);
    run_bad(32'd341);
    // Timeout: no rdone ever
    pulse_req(1'b1, 1'b0, 32'd7);
    tick(); tick();
    n = 0;
    while (rstart[DRV] && n < 2 * TO) begin
      n++;
      tick();
    end
    chk("timeout_len", n, TO);
    tick();
    chk("timeout_done", done, 1'b1);
    chk("timeout_err", err, 1'b1);
    tick();
    run_read(32'd5, 512, 1'b0);
    do_mount(64'h0000_0400_0000_0000);
    run_read(32'hFFFF_FFFE, 4, 1'b0);
    run_bad(32'hFFFF_FFFF);
    // Write request while busy must vanish
    pulse_req(1'b1, 1'b0, 32'd9);
    tick(); tick();
    pulse_req(1'b0, 1'b1, 32'd3);
    chk("ignored_wr", wstart, 8'h00);
    finish_xfer(1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) n++;
      tick();
    end
    chk("no_second_done", n, 0);
    // Reset in the middle of WAIT
    pulse_req(1'b1, 1'b0, 32'd11);
    tick(); tick();
    chk("pre_rst_start", rstart, C_BIT);
    rstn = 1'b0;
    tick();
    chk("midrst_start", {rstart, wstart}, 16'h0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rsector", rsector, 32'd0);
    chk("midrst_inbyte", inbyte, 8'h00);
    rstn = 1'b1;
    tick();
    do_mount(64'd174848);
    run_read(32'd2, 8, 1'b1);                // both strobes: read
    // Randomised traffic against the model
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 1999) == 0) begin
        mounted = 1'b1;
        image_size = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                   : 64'($urandom_range(0, 20)) * 64'd512 + 64'($urandom_range(0, 511));
      end else mounted = 1'b0;
      req_rd     = ($urandom_range(0, 39) == 0);
      req_wr     = ($urandom_range(0, 39) == 0);
      req_sector = 32'($urandom_range(0, 24));
      rdone      = ($urandom_range(0, 149) == 0);
      outen      = $urandom_range(0, 1) == 1;
      outaddr    = 9'($urandom);
      outbyte    = 8'($urandom);
      buf_we     = ($urandom_range(0, 3) == 0);
      buf_addr   = 9'($urandom);
      buf_wdata  = 8'($urandom);
      rbusy      = $urandom_range(0, 1) == 1;
      rstn       = ($urandom_range(0, 2999) != 0);
      tick();
    end
    {mounted, req_rd, req_wr, rdone, outen, buf_we} = 6'b0;
    rstn = 1'b1;
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
